// File: rtl/adder_bist_controller.sv
// adder_bist_controller: built-in self-test sequencer for the ALSU adder slice.
// Sweeps every {op,A,B} vector into the adder and checks Sum/carry/flag
// against an internal reference model. Reports pass, error count, first fail.
//
// Ports:
//   clk, rst (async, active-high), start (one-cycle pulse)
//   A, B, Sel      -> stimulus to the adder (Sel[Width_Sel-1:2] always 0)
//   Sum, carry_out, Negative_Sign_Adder_Flag <- adder response
//   busy, done, pass, error_count, fail_vector -> status (all registered)
//
// Optional feature macro: STOP_ON_FAIL_EN
//   defined   : first mismatch ends the sweep; A/B/Sel hold the failing vector
//   undefined : full sweep always completes
module adder_bist_controller #(
    parameter int Width         = 4,
    parameter int Width_Sel     = 5,
    parameter int Settle_Cycles = 1,
    parameter int Err_Width     = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [Width-1:0]       A,
    output logic [Width-1:0]       B,
    output logic [Width_Sel-1:0]   Sel,
    input  logic [Width-1:0]       Sum,
    input  logic                   carry_out,
    input  logic                   Negative_Sign_Adder_Flag,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [Err_Width-1:0]   error_count,
    output logic [2*Width+1:0]     fail_vector
);

    localparam int IW = 2 * Width + 2;
    localparam int CW = (Settle_Cycles > 1) ? $clog2(Settle_Cycles) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [IW-1:0]        idx_q;
    logic [Width-1:0]     a_q;
    logic [Width-1:0]     b_q;
    logic [1:0]           op_q;
    logic [CW-1:0]        wcnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [Err_Width-1:0] err_q;
    logic [IW-1:0]        fvec_q;

    // Reference model, evaluated on the vector currently driven to the adder
    logic [Width:0]       exp_add;
    logic [Width-1:0]     exp_sum;
    logic                 exp_carry;
    logic                 exp_flag;
    logic                 mismatch;
    logic                 first_err;
    logic [Err_Width-1:0] err_d;

    always_comb begin
        exp_add   = {1'b0, a_q} + {1'b0, b_q};
        exp_sum   = '0;
        exp_carry = 1'b0;
        exp_flag  = 1'b0;
        case (op_q)
            2'b00: begin
                exp_sum   = exp_add[Width-1:0];
                exp_carry = exp_add[Width];
            end
            2'b01: begin
                if (a_q >= b_q) begin
                    exp_sum = a_q - b_q;
                end else begin
                    exp_sum  = b_q - a_q;
                    exp_flag = 1'b1;
                end
            end
            2'b10:   exp_sum = ~b_q + 1'b1;
            default: exp_sum = ~a_q + 1'b1;
        endcase

        mismatch  = (Sum != exp_sum)
                  || (carry_out != exp_carry)
                  || (Negative_Sign_Adder_Flag != exp_flag);
        first_err = (err_q == '0);
        // Saturate rather than wrap so a huge failure never reads as a pass
        err_d     = (&err_q) ? err_q : err_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            wcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fvec_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_APPLY;
                        idx_q   <= '0;
                        err_q   <= '0;
                        fvec_q  <= '0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end

                S_APPLY: begin
                    op_q    <= idx_q[IW-1:IW-2];
                    a_q     <= idx_q[2*Width-1:Width];
                    b_q     <= idx_q[Width-1:0];
                    wcnt_q  <= '0;
                    state_q <= (Settle_Cycles == 0) ? S_CHECK : S_WAIT;
                end

                S_WAIT: begin
                    if (wcnt_q == CW'(Settle_Cycles - 1)) begin
                        state_q <= S_CHECK;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end

                S_CHECK: begin
                    if (mismatch) begin
                        err_q <= err_d;
                        if (first_err) begin
                            fvec_q <= {op_q, a_q, b_q};
                        end
                    end
`ifdef STOP_ON_FAIL_EN
                    // A/B/Sel are left untouched so they keep the failing vector
                    if (mismatch) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b0;
                    end else
`endif
                    if (&idx_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= !mismatch && first_err;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= S_APPLY;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign A           = a_q;
    assign B           = b_q;
    assign Sel         = {{(Width_Sel - 2){1'b0}}, op_q};
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign error_count = err_q;
    assign fail_vector = fvec_q;

endmodule
